// File: rtl/proc_loop_sequencer_if.sv
// Command / beat-issue / retire bundle between the command queue,
// the loop sequencer and the PE datapath.
interface proc_loop_sequencer_if #(
    parameter int CNT_BW  = 8,
    parameter int PROC_BW = 4,
    parameter int NT_BW   = 4,
    parameter int CFG_W   = PROC_BW + NT_BW + 8 + 2 + 3 * CNT_BW + 8
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [CFG_W-1:0]   cfg;
    logic               iss_valid;
    logic               iss_ready;
    logic [PROC_BW-1:0] iss_proc;
    logic               iss_sparse;
    logic [1:0]         iss_func;
    logic [CNT_BW-1:0]  iss_i0;
    logic [CNT_BW-1:0]  iss_i1;
    logic [CNT_BW-1:0]  iss_i2;
    logic               iss_first;
    logic               iss_last;
    logic [7:0]         iss_t;
    logic [NT_BW-1:0]   iss_nt;
    logic [7:0]         iss_n1;
    logic               ret;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output cfg_valid, cfg, iss_ready, ret,
        input  cfg_ready, iss_valid, iss_proc, iss_sparse, iss_func,
        input  iss_i0, iss_i1, iss_i2, iss_first, iss_last,
        input  iss_t, iss_nt, iss_n1, busy, done, err
    );

    modport slave (
        input  cfg_valid, cfg, iss_ready, ret,
        output cfg_ready, iss_valid, iss_proc, iss_sparse, iss_func,
        output iss_i0, iss_i1, iss_i2, iss_first, iss_last,
        output iss_t, iss_nt, iss_n1, busy, done, err
    );
endinterface

// File: rtl/proc_loop_sequencer.sv
// Loop-nest sequencer: one command at a time, one indexed beat per
// inner iteration, bounded outstanding beats, drain then done pulse.
module proc_loop_sequencer #(
    parameter int CNT_BW    = 8,
    parameter int MAX_OUTST = 16,
    parameter int PROC_BW   = 4,
    parameter int NT_BW     = 4
) (
    input logic                 clk,
    input logic                 rst,
    proc_loop_sequencer_if.slave bus
);
    localparam int OW = $clog2(MAX_OUTST + 1);

    localparam logic [PROC_BW-1:0] P_IDLE  = PROC_BW'(0);
    localparam logic [PROC_BW-1:0] P_MTXV  = PROC_BW'(2);
    localparam logic [PROC_BW-1:0] P_VXV   = PROC_BW'(3);
    localparam logic [PROC_BW-1:0] P_SP_LO = PROC_BW'(4);
    localparam logic [PROC_BW-1:0] P_MAX   = PROC_BW'(6);

    typedef struct packed {
        logic [PROC_BW-1:0] proc;
        logic [NT_BW-1:0]   nt;
        logic [7:0]         t;
        logic [1:0]         func;
        logic [CNT_BW-1:0]  cnt0;
        logic [CNT_BW-1:0]  cnt1;
        logic [CNT_BW-1:0]  cnt2;
        logic [7:0]         n1;
    } cfg_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    cfg_t              c_in, c_map, c_q;
    logic              sp_in, sparse_q, tr_q;
    logic [CNT_BW-1:0] i0, i1, i2;
    logic [CNT_BW-1:0] i0_n, i1_n, i2_n;
    logic [OW-1:0]     outst;
    logic              err_q;
    logic              accept, bad_proc, idle_proc;
    logic              issue, last, ret_ok, ret_bad;

    assign c_in      = cfg_t'(bus.cfg);
    assign accept    = (state == IDLE) && bus.cfg_valid;
    assign bad_proc  = c_in.proc > P_MAX;
    assign idle_proc = c_in.proc == P_IDLE;

    assign last = (i0 == c_q.cnt0) && (i1 == c_q.cnt1) && (i2 == c_q.cnt2);

    assign bus.iss_valid = (state == RUN) && (outst < OW'(MAX_OUTST));
    assign issue   = bus.iss_valid && bus.iss_ready;
    assign ret_ok  = bus.ret && ((outst != '0) || issue);
    assign ret_bad = bus.ret && !ret_ok;

    assign bus.cfg_ready  = state == IDLE;
    assign bus.busy       = state != IDLE;
    assign bus.done       = state == DONE;
    assign bus.err        = err_q;
    assign bus.iss_proc   = c_q.proc;
    assign bus.iss_sparse = sparse_q;
    assign bus.iss_func   = c_q.func;
    assign bus.iss_t      = c_q.t;
    assign bus.iss_nt     = c_q.nt;
    assign bus.iss_n1     = c_q.n1;
    assign bus.iss_i0     = i0;
    assign bus.iss_i1     = i1;
    assign bus.iss_i2     = i2;
    assign bus.iss_first  = (state == RUN) && (i0 == '0) && (i1 == '0) && (i2 == '0);
    assign bus.iss_last   = (state == RUN) && last;

    // Map sparse codes onto dense ones; VXV collapses to a single loop
    always_comb begin
        c_map = c_in;
        sp_in = (c_in.proc >= P_SP_LO) && (c_in.proc <= P_MAX);
        if (sp_in) c_map.proc = c_in.proc - PROC_BW'(3);
        if (c_map.proc == P_VXV) begin
            c_map.cnt1 = '0;
            c_map.cnt2 = '0;
        end
    end

    // Next loop indices: MTxV runs i1 innermost, everything else i0
    always_comb begin
        i0_n = i0;
        i1_n = i1;
        i2_n = i2;
        if (!tr_q) begin
            if (i0 != c_q.cnt0) begin
                i0_n = i0 + 1'b1;
            end else begin
                i0_n = '0;
                if (i1 != c_q.cnt1) begin
                    i1_n = i1 + 1'b1;
                end else begin
                    i1_n = '0;
                    i2_n = i2 + 1'b1;
                end
            end
        end else begin
            if (i1 != c_q.cnt1) begin
                i1_n = i1 + 1'b1;
            end else begin
                i1_n = '0;
                if (i0 != c_q.cnt0) begin
                    i0_n = i0 + 1'b1;
                end else begin
                    i0_n = '0;
                    i2_n = i2 + 1'b1;
                end
            end
        end
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (bus.cfg_valid) state_nxt = (idle_proc || bad_proc) ? DONE : RUN;
            RUN:   if (issue && last) state_nxt = DRAIN;
            DRAIN: if (outst == '0) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Command latch, loop indices, outstanding count and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            c_q      <= '0;
            sparse_q <= 1'b0;
            tr_q     <= 1'b0;
            i0       <= '0;
            i1       <= '0;
            i2       <= '0;
            outst    <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                c_q      <= c_map;
                sparse_q <= sp_in;
                tr_q     <= c_map.proc == P_MTXV;
                i0       <= '0;
                i1       <= '0;
                i2       <= '0;
            end else if (issue) begin
                i0 <= i0_n;
                i1 <= i1_n;
                i2 <= i2_n;
            end
            outst <= outst + OW'(issue) - OW'(ret_ok);
            if ((accept && bad_proc) || ret_bad) err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_proc_loop_sequencer.sv
// Directed self-checking bench for proc_loop_sequencer.
// Beats are logged on handshake; retires can follow beats by 3 cycles.
module tb_proc_loop_sequencer;
    logic clk;
    logic rst;

    proc_loop_sequencer_if sif ();

    proc_loop_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nb, dn, acc_cyc, first_cyc, last_cyc, done_cyc;
    logic [2:0] pipe;
    bit ret_auto;
    logic [7:0] b0 [64];
    logic [7:0] b1 [64];
    logic [7:0] b2 [64];
    logic       bf [64];
    logic       bl [64];
    logic [3:0] bp [64];
    logic       bs [64];

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [49:0] mk(input logic [3:0] p, input int c0, input int c1,
                                       input int c2);
        return {p, 4'h3, 8'h5A, 2'd2, 8'(c0), 8'(c1), 8'(c2), 8'h11};
    endfunction

    function automatic logic [63:0] snap();
        return {11'd0, sif.iss_proc, sif.iss_sparse, sif.iss_func, sif.iss_i0, sif.iss_i1,
                sif.iss_i2, sif.iss_first, sif.iss_last, sif.iss_t, sif.iss_nt, sif.iss_n1};
    endfunction

    task automatic tick();
        logic hs;
        hs = sif.iss_valid && sif.iss_ready && !rst;
        if (hs) begin
            if (nb == 0) first_cyc = cyc;
            if (sif.iss_last) last_cyc = cyc;
            if (nb < 64) begin
                b0[nb] = sif.iss_i0;
                b1[nb] = sif.iss_i1;
                b2[nb] = sif.iss_i2;
                bf[nb] = sif.iss_first;
                bl[nb] = sif.iss_last;
                bp[nb] = sif.iss_proc;
                bs[nb] = sif.iss_sparse;
            end
            nb++;
        end
        if (sif.done) begin
            dn++;
            done_cyc = cyc;
        end
        if (sif.cfg_valid && sif.cfg_ready && !rst) acc_cyc = cyc;
        @(posedge clk);
        #1;
        cyc++;
        pipe = rst ? 3'b000 : {pipe[1:0], hs};
        if (ret_auto) sif.ret = pipe[2];
    endtask

    task automatic clear();
        nb = 0;
        dn = 0;
        acc_cyc = -1;
        first_cyc = -1;
        last_cyc = -1;
        done_cyc = -1;
    endtask

    task automatic send(input logic [49:0] c);
        sif.cfg = c;
        sif.cfg_valid = 1'b1;
        tick();
        sif.cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int n = 0;
        while (dn == 0 && n < bound) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, dn, 1);
        repeat (3) tick();
        check({tag, "_done_once"}, dn, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sif.cfg_valid = 1'b0;
        sif.ret = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        pipe = 3'b000;
    endtask

    initial begin
        int stalls, bad, n;
        bit prev_stall;
        logic [63:0] sv;

        rst = 1'b1;
        sif.cfg_valid = 1'b0;
        sif.cfg = '0;
        sif.iss_ready = 1'b0;
        sif.ret = 1'b0;
        ret_auto = 1'b0;
        pipe = 3'b000;
        clear();
        repeat (3) tick();
        rst = 1'b0;

        check("rst_cfg_ready", sif.cfg_ready, 1);
        check("rst_iss_valid", sif.iss_valid, 0);
        check("rst_busy", sif.busy, 0);
        check("rst_done", sif.done, 0);
        check("rst_err", sif.err, 0);
        check("rst_first_last", {sif.iss_first, sif.iss_last}, 0);
        check("rst_proc_idx", {sif.iss_proc, sif.iss_i0}, 0);

        // 1: MxV 3x2 with retires 3 cycles behind
        clear();
        sif.iss_ready = 1'b1;
        ret_auto = 1'b1;
        send(mk(4'd1, 2, 1, 0));
        check("t1_busy", sif.busy, 1);
        check("t1_cfg_ready", sif.cfg_ready, 0);
        check("t1_latched", {sif.iss_t, sif.iss_nt, sif.iss_func, sif.iss_n1},
              {8'h5A, 4'h3, 2'd2, 8'h11});
        wait_done("t1", 60);
        check("t1_beats", nb, 6);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("t1_idx%0d", k), {b2[k], b1[k], b0[k]},
                  {8'd0, 8'(k / 3), 8'(k % 3)});
            check($sformatf("t1_fl%0d", k), {bf[k], bl[k]}, {k == 0, k == 5});
        end
        check("t1_proc", {bp[0], bs[0]}, {4'd1, 1'b0});
        check("t1_zero_bubble", first_cyc - acc_cyc, 1);
        check("t1_back_to_back", last_cyc - first_cyc, 5);
        check("t1_done_latency", done_cyc - last_cyc, 5);
        check("t1_err", sif.err, 0);

        // 2: MTxV_SP, i1 innermost
        clear();
        send(mk(4'd5, 1, 2, 0));
        wait_done("t2", 60);
        check("t2_beats", nb, 6);
        for (int k = 0; k < 6; k++)
            check($sformatf("t2_idx%0d", k), {b2[k], b1[k], b0[k]},
                  {8'd0, 8'(k % 3), 8'(k / 3)});
        check("t2_proc_sparse", {bp[0], bs[0], bp[5], bs[5]}, {4'd2, 1'b1, 4'd2, 1'b1});

        // 3: VXV with stalls every other cycle
        clear();
        send(mk(4'd3, 3, 5, 7));
        stalls = 0;
        bad = 0;
        prev_stall = 1'b0;
        sv = '0;
        n = 0;
        while (dn == 0 && n < 80) begin
            sif.iss_ready = n[0];
            if (prev_stall && snap() !== sv) bad++;
            prev_stall = sif.iss_valid && !sif.iss_ready;
            if (prev_stall) stalls++;
            sv = snap();
            tick();
            n++;
        end
        sif.iss_ready = 1'b1;
        check("t3_done_seen", dn, 1);
        check("t3_beats", nb, 4);
        for (int k = 0; k < 4; k++)
            check($sformatf("t3_idx%0d", k), {b2[k], b1[k], b0[k]}, {16'd0, 8'(k)});
        check("t3_last", {bf[0], bl[3], bl[2]}, 3'b110);
        check("t3_stalls_seen", stalls > 0, 1);
        check("t3_stall_stable", bad, 0);

        // 4: 64-beat MxV, no retires until the outstanding window fills
        clear();
        ret_auto = 1'b0;
        sif.ret = 1'b0;
        send(mk(4'd1, 63, 0, 0));
        repeat (25) tick();
        check("t4_window_full", nb, 16);
        check("t4_valid_low", sif.iss_valid, 0);
        sif.ret = 1'b1;
        tick();
        sif.ret = 1'b0;
        repeat (4) tick();
        check("t4_one_more", nb, 17);
        check("t4_valid_low2", sif.iss_valid, 0);
        sif.ret = 1'b1;
        tick();
        tick();
        sif.ret = 1'b0;
        repeat (4) tick();
        check("t4_issue_ret_same", nb, 19);
        check("t4_valid_low3", sif.iss_valid, 0);
        check("t4_err", sif.err, 0);
        do_reset();
        check("t4_no_done", dn, 0);

        // 5: PROC_IDLE, bad proc, stray retire
        clear();
        send(mk(4'd0, 3, 3, 3));
        repeat (3) tick();
        check("t5_idle_done", dn, 1);
        check("t5_idle_lat", done_cyc - acc_cyc, 1);
        check("t5_idle_beats", nb, 0);
        check("t5_idle_err", sif.err, 0);
        clear();
        send(mk(4'd9, 3, 3, 3));
        repeat (3) tick();
        check("t5_bad_err", sif.err, 1);
        check("t5_bad_done", dn, 1);
        check("t5_bad_beats", nb, 0);
        do_reset();
        check("t5_err_cleared", sif.err, 0);
        sif.ret = 1'b1;
        tick();
        sif.ret = 1'b0;
        tick();
        check("t5_ret_idle_err", sif.err, 1);
        check("t5_ret_idle_ready", sif.cfg_ready, 1);
        do_reset();

        // 6: reset on beat 5 of a 64-beat command, then a clean run
        clear();
        ret_auto = 1'b1;
        sif.iss_ready = 1'b1;
        send(mk(4'd1, 63, 0, 0));
        n = 0;
        while (nb < 4 && n < 20) begin
            tick();
            n++;
        end
        check("t6_four_beats", nb, 4);
        check("t6_beat5_valid", sif.iss_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_valid_low", sif.iss_valid, 0);
        check("t6_cfg_ready", sif.cfg_ready, 1);
        check("t6_busy", sif.busy, 0);
        repeat (5) tick();
        check("t6_no_done", dn, 0);
        check("t6_err", sif.err, 0);
        clear();
        send(mk(4'd1, 1, 1, 0));
        wait_done("t6b", 60);
        check("t6b_beats", nb, 4);
        for (int k = 0; k < 4; k++)
            check($sformatf("t6b_idx%0d", k), {b2[k], b1[k], b0[k]},
                  {8'd0, 8'(k / 2), 8'(k % 2)});
        check("t6b_err", sif.err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
